branch_pc_controller: RTL and testbench
=======================================

# branch_pc_controller

Program-sequencing controller for the streaming IPPro core. Generates the program counter for instruction fetch, resolves branches by combining the branch handler's per-instruction condition mask with the datapath status flags, and redirects fetch to the branch target. It squashes wrong-path instructions through a flush pulse and a shadow window, and loops the kernel program once per pixel between configurable start and end addresses. Sits between the instruction memory and the branch handler / execute stages.

## Interface
- ADDR_WIDTH, 10, program-memory address width (matches branch target width)
- FLAGS_LENGTH, 8, width of condition mask and status flags
- SHADOW_CYCLES, 4, number of cycles after a taken branch during which branch resolution is suppressed (pipeline depth between fetch and branch handler output)
- ITER_WIDTH, 16, width of the kernel iteration counter

- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  global pipeline advance; low = all state holds
- START  in  1  begin execution; sampled only in IDLE
- STOP  in  1  request halt at the end of the current kernel iteration
- START_ADDR  in  ADDR_WIDTH  first instruction of the kernel loop
- END_ADDR  in  ADDR_WIDTH  last instruction of the kernel loop
- IM_FLAGS  in  FLAGS_LENGTH  branch condition mask from the branch handler (0 = not a branch)
- ALU_FLAGS  in  FLAGS_LENGTH  datapath status flags; carries both polarities of each condition
- BADDR  in  ADDR_WIDTH  branch target, aligned with IM_FLAGS
- PC  out  ADDR_WIDTH  fetch address
- FETCH_EN  out  1  PC is valid this cycle
- FLUSH  out  1  one-cycle pulse: squash all in-flight instructions
- BRANCH_TAKEN  out  1  one-cycle pulse coincident with FLUSH
- LOOP_DONE  out  1  one-cycle pulse when a kernel iteration completes
- BUSY  out  1  state is not IDLE
- ITER_CNT  out  ITER_WIDTH  completed iterations since START

## Operation
- States: IDLE, RUN, SHADOW.
- taken = (|(IM_FLAGS & ALU_FLAGS)) and state == RUN and ENABLE.
- IDLE: FETCH_EN=0, PC holds. START & ENABLE -> PC=START_ADDR, ITER_CNT=0, stop_req=0, go RUN.
- RUN, per enabled cycle, priority order:
  1. taken: PC=BADDR, FLUSH=1, BRANCH_TAKEN=1, shadow counter=SHADOW_CYCLES-1, go SHADOW.
  2. PC==END_ADDR: LOOP_DONE=1, ITER_CNT+1 (wraps modulo 2^ITER_WIDTH). If stop_req or STOP then go IDLE (PC holds END_ADDR), else PC=START_ADDR.
  3. else PC=PC+1 modulo 2^ADDR_WIDTH.
- SHADOW: PC advances and END_ADDR wrap behaves as in RUN items 2-3, but IM_FLAGS is ignored (wrong-path or refetched instructions). The counter decrements each enabled cycle; at 0, return to RUN. If the end-of-iteration stop occurs in SHADOW, go IDLE.
- STOP is latched into stop_req whenever it is high in RUN/SHADOW. It is cleared on START.
- START outside IDLE is ignored. STOP in IDLE is ignored.
- ENABLE low: PC, state, counters, stop_req hold. FLUSH, BRANCH_TAKEN, and LOOP_DONE are forced to 0 (pulses never stretch).
- FETCH_EN = 1 in RUN and SHADOW, 0 in IDLE.
- END_ADDR comparison is equality only. If START_ADDR > END_ADDR, the PC wraps through 2^ADDR_WIDTH-1 to 0 before reaching END_ADDR.

## Timing
- All outputs are registered. Reset values: PC=0, FETCH_EN=0, FLUSH=0, BRANCH_TAKEN=0, LOOP_DONE=0, BUSY=0, ITER_CNT=0, state=IDLE, stop_req=0, shadow counter=0.
- RESET wins over every input, including START and ENABLE. Reset during RUN/SHADOW returns to IDLE on the next edge, and no pulses are emitted.
- START in cycle t (ENABLE=1): PC=START_ADDR, FETCH_EN=1 at t+1.
- taken sampled in cycle t: PC=BADDR, FLUSH=BRANCH_TAKEN=1 at t+1. IM_FLAGS is ignored in cycles t+1..t+SHADOW_CYCLES. A taken branch can be resolved again from t+SHADOW_CYCLES+1.
- Branch whose BADDR equals END_ADDR: PC=END_ADDR at t+1, and the loop completes normally the next enabled cycle.
- Taken branch in the same cycle PC==END_ADDR: the branch wins, and no LOOP_DONE is emitted.
- Iteration of N=END_ADDR-START_ADDR+1 instructions without branches: LOOP_DONE every N enabled cycles.

## Test plan
- Reset mid-RUN with PC=0x05A, START=1 -> next cycle all outputs at reset values. START held -> RUN one cycle after RESET drops.
- START_ADDR=0x010, END_ADDR=0x013, no branches, 3 iterations -> PC sequence 10,11,12,13,10,…; LOOP_DONE at each 13->10; ITER_CNT=3.
- IM_FLAGS=0x01, ALU_FLAGS=0x01, BADDR=0x200 at PC=0x012 -> next cycle PC=0x200, FLUSH=BRANCH_TAKEN=1 for exactly one cycle. Matching IM_FLAGS on the next 4 cycles -> ignored. Match on cycle 5 -> taken.
- IM_FLAGS=0x02 with ALU_FLAGS=0x01 -> not taken, PC increments. Taken at PC==END_ADDR -> PC=BADDR, no LOOP_DONE, ITER_CNT unchanged.
- ENABLE low for 3 cycles during SHADOW -> PC/counter frozen, no pulses. The shadow resumes with the remaining count.
- STOP pulsed mid-iteration -> iteration completes, LOOP_DONE=1, BUSY=0, FETCH_EN=0, PC=END_ADDR. Also START_ADDR=0x3FE, END_ADDR=0x001 -> PC 3FE,3FF,000,001.

Source files
------------

// File: rtl/branch_pc_controller.sv
// branch_pc_controller
//   Program sequencer for the streaming IPPro core. It generates the fetch PC
//   and runs the kernel from START_ADDR to END_ADDR once per pixel. It takes
//   a branch when the branch handler's condition mask matches the datapath
//   flags. After a taken branch it opens a shadow window of SHADOW_CYCLES
//   cycles in which branch resolution is suppressed.
//
// Ports
//   CLK, RESET    clock, synchronous active-high reset
//   ENABLE        pipeline advance; low freezes all state, pulses read 0
//   START         begin execution (IDLE only)
//   STOP          halt at the end of the current kernel iteration
//   START_ADDR    first kernel instruction
//   END_ADDR      last kernel instruction
//   IM_FLAGS      branch condition mask (0 = not a branch)
//   ALU_FLAGS     datapath status flags
//   BADDR         branch target, aligned with IM_FLAGS
//   PC            fetch address
//   FETCH_EN      PC valid
//   FLUSH         one-cycle squash pulse on a taken branch
//   BRANCH_TAKEN  one-cycle pulse coincident with FLUSH
//   LOOP_DONE     one-cycle pulse per completed iteration
//   BUSY          controller not idle
//   ITER_CNT      iterations completed since START
module branch_pc_controller #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned FLAGS_LENGTH  = 8,
    parameter int unsigned SHADOW_CYCLES = 4,
    parameter int unsigned ITER_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    START,
    input  logic                    STOP,
    input  logic [ADDR_WIDTH-1:0]   START_ADDR,
    input  logic [ADDR_WIDTH-1:0]   END_ADDR,
    input  logic [FLAGS_LENGTH-1:0] IM_FLAGS,
    input  logic [FLAGS_LENGTH-1:0] ALU_FLAGS,
    input  logic [ADDR_WIDTH-1:0]   BADDR,
    output logic [ADDR_WIDTH-1:0]   PC,
    output logic                    FETCH_EN,
    output logic                    FLUSH,
    output logic                    BRANCH_TAKEN,
    output logic                    LOOP_DONE,
    output logic                    BUSY,
    output logic [ITER_WIDTH-1:0]   ITER_CNT
);

    localparam int unsigned SH_W = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SHADOW = 2'd2
    } state_t;

    state_t          state;
    logic            stop_req;
    logic [SH_W-1:0] shadow_cnt;

    logic taken;
    logic at_end;
    logic stopping;

    always_comb begin
        taken    = (|(IM_FLAGS & ALU_FLAGS)) && (state == RUN) && ENABLE;
        at_end   = (PC == END_ADDR);
        // A STOP arriving in the very cycle the iteration ends still counts.
        stopping = at_end && (stop_req || STOP);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            stop_req     <= 1'b0;
            shadow_cnt   <= '0;
            PC           <= '0;
            FETCH_EN     <= 1'b0;
            FLUSH        <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
            LOOP_DONE    <= 1'b0;
            BUSY         <= 1'b0;
            ITER_CNT     <= '0;
        end else begin
            FLUSH        <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
            LOOP_DONE    <= 1'b0;
            if (ENABLE) begin
                case (state)
                    IDLE: begin
                        if (START) begin
                            PC       <= START_ADDR;
                            ITER_CNT <= '0;
                            stop_req <= 1'b0;
                            state    <= RUN;
                            FETCH_EN <= 1'b1;
                            BUSY     <= 1'b1;
                        end
                    end
                    RUN, SHADOW: begin
                        if (STOP) stop_req <= 1'b1;
                        if (taken) begin
                            PC           <= BADDR;
                            FLUSH        <= 1'b1;
                            BRANCH_TAKEN <= 1'b1;
                            shadow_cnt   <= SH_W'(SHADOW_CYCLES - 1);
                            state        <= SHADOW;
                        end else begin
                            if (at_end) begin
                                LOOP_DONE <= 1'b1;
                                ITER_CNT  <= ITER_CNT + 1'b1;
                                if (!stopping) PC <= START_ADDR;
                            end else begin
                                PC <= PC + 1'b1;
                            end
                            // Halting takes precedence over the shadow countdown.
                            if (stopping) begin
                                state      <= IDLE;
                                shadow_cnt <= '0;
                                FETCH_EN   <= 1'b0;
                                BUSY       <= 1'b0;
                            end else if (state == SHADOW) begin
                                if (shadow_cnt == '0) state <= RUN;
                                else                  shadow_cnt <= shadow_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        FETCH_EN <= 1'b0;
                        BUSY     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_pc_controller.sv
// Testbench for branch_pc_controller: directed scenarios followed by random
// traffic, every cycle compared against a cycle-count based reference model.
module tb_branch_pc_controller;

    localparam int unsigned AW = 10;
    localparam int unsigned FW = 8;
    localparam int unsigned S  = 4;
    localparam int unsigned IW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic          START;
    logic          STOP;
    logic [AW-1:0] START_ADDR;
    logic [AW-1:0] END_ADDR;
    logic [FW-1:0] IM_FLAGS;
    logic [FW-1:0] ALU_FLAGS;
    logic [AW-1:0] BADDR;
    logic [AW-1:0] PC;
    logic          FETCH_EN;
    logic          FLUSH;
    logic          BRANCH_TAKEN;
    logic          LOOP_DONE;
    logic          BUSY;
    logic [IW-1:0] ITER_CNT;

    branch_pc_controller #(
        .ADDR_WIDTH   (AW),
        .FLAGS_LENGTH (FW),
        .SHADOW_CYCLES(S),
        .ITER_WIDTH   (IW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .START       (START),
        .STOP        (STOP),
        .START_ADDR  (START_ADDR),
        .END_ADDR    (END_ADDR),
        .IM_FLAGS    (IM_FLAGS),
        .ALU_FLAGS   (ALU_FLAGS),
        .BADDR       (BADDR),
        .PC          (PC),
        .FETCH_EN    (FETCH_EN),
        .FLUSH       (FLUSH),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .LOOP_DONE   (LOOP_DONE),
        .BUSY        (BUSY),
        .ITER_CNT    (ITER_CNT)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: the controller is either running or not; a taken
    // branch blocks further branches until a given enabled-cycle number.
    int unsigned m_pc;
    int unsigned m_iter;
    bit          m_busy;
    bit          m_stopreq;
    bit          m_flush;
    bit          m_loopdone;
    longint      ecyc;
    longint      no_branch_until;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_update();
        if (RESET) begin
            m_pc = 0; m_iter = 0; m_busy = 0; m_stopreq = 0;
            m_flush = 0; m_loopdone = 0;
            no_branch_until = ecyc;
        end else begin
            m_flush = 0;
            m_loopdone = 0;
            if (ENABLE) begin
                if (!m_busy) begin
                    if (START) begin
                        m_pc = START_ADDR; m_iter = 0; m_stopreq = 0; m_busy = 1;
                        no_branch_until = ecyc;
                    end
                end else begin
                    if (STOP) m_stopreq = 1;
                    if ((IM_FLAGS & ALU_FLAGS) != 0 && ecyc > no_branch_until) begin
                        m_pc = BADDR;
                        m_flush = 1;
                        no_branch_until = ecyc + S;
                    end else if (m_pc == END_ADDR) begin
                        m_loopdone = 1;
                        m_iter = (m_iter + 1) % (1 << IW);
                        if (m_stopreq) m_busy = 0;
                        else           m_pc = START_ADDR;
                    end else begin
                        m_pc = (m_pc + 1) % (1 << AW);
                    end
                end
                ecyc++;
            end
        end
    endtask

    task automatic check_all();
        chk("pc",        32'(PC),           32'(m_pc));
        chk("fetch_en",  32'(FETCH_EN),     32'(m_busy));
        chk("busy",      32'(BUSY),         32'(m_busy));
        chk("flush",     32'(FLUSH),        32'(m_flush));
        chk("br_taken",  32'(BRANCH_TAKEN), 32'(m_flush));
        chk("loop_done", 32'(LOOP_DONE),    32'(m_loopdone));
        chk("iter_cnt",  32'(ITER_CNT),     32'(m_iter));
    endtask

    task automatic step(input logic s, input logic st, input logic e,
                        input logic [FW-1:0] im, input logic [FW-1:0] alu,
                        input logic [AW-1:0] ba);
        START = s; STOP = st; ENABLE = e;
        IM_FLAGS = im; ALU_FLAGS = alu; BADDR = ba;
        @(posedge CLK);
        model_update();
        #1;
        check_all();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 1, '0, '0, '0);
    endtask

    initial begin
        ecyc = 0; no_branch_until = 0;
        START = 0; STOP = 0; ENABLE = 0; IM_FLAGS = '0; ALU_FLAGS = '0; BADDR = '0;
        START_ADDR = 10'h050; END_ADDR = 10'h0FF;

        // Reset state
        RESET = 1;
        step(0, 0, 1, '0, '0, '0);
        step(0, 0, 1, '0, '0, '0);
        RESET = 0;

        // Reset mid-RUN with PC=0x05A while START is held
        step(1, 0, 1, '0, '0, '0);
        run(10);
        chk("pc_5a", 32'(PC), 32'h05A);
        RESET = 1;
        step(1, 0, 1, 8'hFF, 8'hFF, 10'h3AA);
        chk("rst_pc", 32'(PC), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        RESET = 0;
        step(1, 0, 1, '0, '0, '0);
        chk("restart_pc", 32'(PC), 32'h050);
        chk("restart_busy", 32'(BUSY), 32'h1);

        // Plain kernel loop 0x010..0x013, three iterations
        RESET = 1; step(0, 0, 1, '0, '0, '0); RESET = 0;
        START_ADDR = 10'h010; END_ADDR = 10'h013;
        step(1, 0, 1, '0, '0, '0);
        run(12);
        chk("iter3", 32'(ITER_CNT), 32'd3);
        chk("iter3_pc", 32'(PC), 32'h010);

        // Branch at PC=0x012, shadow of S cycles, then a second branch
        run(2);
        step(0, 0, 1, 8'h01, 8'h01, 10'h200);
        chk("br_pc", 32'(PC), 32'h200);
        chk("br_flush", 32'(FLUSH), 32'h1);
        for (int unsigned i = 0; i < S; i++) step(0, 0, 1, 8'h01, 8'h01, 10'h011);
        chk("shadow_pc", 32'(PC), 32'h204);
        step(0, 0, 1, 8'h01, 8'h01, 10'h011);
        chk("br2_pc", 32'(PC), 32'h011);
        chk("br2_taken", 32'(BRANCH_TAKEN), 32'h1);
        run(S);

        // Mask mismatch, then branch exactly at END_ADDR
        step(0, 0, 1, 8'h02, 8'h01, 10'h100);
        for (int unsigned i = 0; i < 8 && m_pc != 32'h013; i++) run(1);
        step(0, 0, 1, 8'h80, 8'h80, 10'h010);
        chk("br_end_ld", 32'(LOOP_DONE), 32'h0);

        // ENABLE low for 3 cycles inside the shadow window
        step(0, 0, 1, '0, '0, '0);
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 8'hFF, 8'hFF, 10'h3FF);
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 8'h04, 8'h04, 10'h000);
        run(S);

        // STOP mid-iteration completes the iteration then idles at END_ADDR
        step(0, 1, 1, '0, '0, '0);
        for (int unsigned i = 0; i < 16 && m_busy; i++) run(1);
        chk("stop_busy", 32'(BUSY), 32'h0);
        chk("stop_pc", 32'(PC), 32'h013);
        run(3);

        // START_ADDR > END_ADDR wraps through 0x3FF
        START_ADDR = 10'h3FE; END_ADDR = 10'h001;
        step(1, 0, 1, '0, '0, '0);
        run(3);
        chk("wrap_pc", 32'(PC), 32'h001);
        run(2);

        // Random traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            logic [FW-1:0] im;
            logic [AW-1:0] ba;
            RESET = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) begin
                START_ADDR = AW'($urandom);
                END_ADDR   = START_ADDR + AW'($urandom_range(0, 12));
            end
            im = ($urandom_range(0, 3) == 0) ? FW'($urandom) : '0;
            ba = ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                             : START_ADDR + AW'($urandom_range(0, 12));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 4) != 0, im, FW'($urandom), ba);
        end
        RESET = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
